mem_fill_responder: RTL and testbench
=====================================

# mem_fill_responder

Pipelined main-memory responder at the far end of the cache-fill interface. It accepts one word request per cycle from the fill FSM or the write-through path, and performs writes immediately. Each read is answered with data and a one-cycle `data_valid` strobe a fixed `LATENCY` cycles later, so an 8-word block fill issued back-to-back returns 8 consecutive valid words. It sits below the shared I/D fill arbitration logic and replaces the behavioural main memory in the cache subsystem.

## Interface
- `LATENCY`, 4, read request-to-response delay in cycles; legal range 1..8
- `DEPTH_LOG2`, 12, log2 of storage depth in 16-bit words
- `clk`  input  1  single clock, all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `enable`  input  1  request present this cycle
- `wr`  input  1  1 = write request, 0 = read request; qualified by `enable`
- `addr`  input  16  byte address; `addr[0]` ignored; word index = `addr[DEPTH_LOG2:1]`; upper bits ignored (aliasing)
- `data_in`  input  16  write data, sampled with the request
- `data_out`  output  16  read data; valid only while `data_valid`=1, forced to 0 otherwise
- `data_valid`  output  1  one-cycle strobe per read response
- `pending`  output  4  number of reads issued and not yet answered, 0..LATENCY

## Operation
- Request accepted every cycle `enable`=1; no backpressure and no ready signal.
- Write (`enable`=1, `wr`=1): storage[word index] <= `data_in` at that clock edge. Produces no response and does not touch `pending`.
- Read (`enable`=1, `wr`=0): word is read at issue and carried down a `LATENCY`-deep valid/data pipeline. Responses return strictly in issue order.
- Read issued the cycle after a write to the same word returns the new data.
- A read and write cannot share a cycle; `wr` selects exactly one.
- Write to a word with a read in flight:
  - default: the in-flight read returns the value as of its issue cycle;
  - with forwarding compiled in: see Configuration.
- `pending` update rules:
  - +1 on read issue;
  - −1 on response;
  - both in the same cycle: unchanged;
  - never exceeds `LATENCY`, because at most one read is issued per cycle.
- Storage contents are not reset.

## Timing
- Read presented in cycle N produces `data_valid`=1 and the corresponding `data_out` in cycle N+`LATENCY`, for exactly one cycle.
- Back-to-back reads in cycles N..N+k produce valid responses in cycles N+`LATENCY`..N+k+`LATENCY`, with no gaps.
- Write takes effect at the edge ending the cycle it is presented.
- `pending` is registered and reflects the state after the current edge.
- Reset (async assert): `data_valid`=0, `data_out`=0, `pending`=0, all pipeline valid bits cleared immediately.
  - In-flight reads are discarded and never answered, including when reset is asserted mid-fill.
  - Storage keeps its values.
- Reset deassertion: requests are accepted from the first rising edge with `rst_n`=1.

## Configuration
- `MEM_RAW_FORWARD_EN` defined:
  - every write compares its word index against each valid pipeline stage's index;
  - matching stages have their carried data replaced with `data_in` at the same edge;
  - the response therefore returns the newest value.
- Undefined: no comparators; in-flight reads return issue-time data.
- Interface and latency are identical in both builds.

## Test plan
- Reset: hold `rst_n`=0 with `enable` toggling -> `data_valid`=0, `data_out`=0x0000, `pending`=0 throughout.
- Single read: write 0xBEEF to 0x0010 in cycle 0, read 0x0010 in cycle 1 -> `data_valid`=1 with `data_out`=0xBEEF in cycle 5 only; `pending`=1 after edges 1–4, 0 after edge 5.
- Block fill: write 0x1000+i to addresses 0x0040+2i (i=0..7), then read all 8 back-to-back in cycles 10..17 -> responses 0x1000..0x1007 in cycles 14..21; `pending` holds 4 from edge 13 through 17.
- Write during fill: read 0x0020 (holding 0x1111) in cycle 0, write 0x2222 to 0x0020 in cycle 2 -> cycle 4 returns 0x1111 without the macro, 0x2222 with `MEM_RAW_FORWARD_EN`.
- Mid-fill reset: issue reads in cycles 0..3, pulse `rst_n` low in cycle 2 -> no `data_valid` ever; `pending`=0; a read issued after release returns correct data after `LATENCY` cycles.
- Aliasing and odd address: write 0xA5A5 to 0x0003, read 0x0002 and 0x2002 (with `DEPTH_LOG2`=12) -> both return 0xA5A5.

Source files
------------

// File: rtl/mem_fill_responder.sv
// ============================================================================
//  Module      : mem_fill_responder
//  Description : Pipelined main-memory responder for the cache-fill interface.
//                Writes commit at once; reads return after LATENCY cycles.
//                Optional build macro: MEM_RAW_FORWARD_EN (forward writes into
//                in-flight reads).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_fill_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [3:0]  pending
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           r_mem [c_DEPTH];
    logic [LATENCY-1:0]    r_vld;
    logic [15:0]           r_data [LATENCY];
    logic [3:0]            r_pending;
`ifdef MEM_RAW_FORWARD_EN
    logic [DEPTH_LOG2-1:0] r_idx [LATENCY];
`endif

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_unused;

    assign w_idx    = addr[DEPTH_LOG2:1];
    assign w_rd     = enable & ~wr;
    assign w_wr     = enable & wr;
    assign w_unused = &{1'b0, addr[15:DEPTH_LOG2+1], addr[0]};

    // Storage is deliberately outside the reset domain; writes are ignored while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr) begin
            r_mem[w_idx] <= data_in;
        end
    end

    // Non-valid stages carry zero so the last stage drives data_out directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            r_pending <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_data[i] <= '0;
`ifdef MEM_RAW_FORWARD_EN
                r_idx[i]  <= '0;
`endif
            end
        end else begin
            r_vld[0]  <= w_rd;
            r_data[0] <= w_rd ? r_mem[w_idx] : 16'h0000;
`ifdef MEM_RAW_FORWARD_EN
            r_idx[0]  <= w_idx;
`endif
            for (int i = 1; i < LATENCY; i++) begin
                r_vld[i]  <= r_vld[i-1];
                r_data[i] <= r_data[i-1];
`ifdef MEM_RAW_FORWARD_EN
                r_idx[i]  <= r_idx[i-1];
                if (w_wr && r_vld[i-1] && (r_idx[i-1] == w_idx)) begin
                    r_data[i] <= data_in;
                end
`endif
            end
            r_pending <= r_pending + {3'b000, w_rd} - {3'b000, r_vld[LATENCY-1]};
        end
    end

    assign data_out   = r_data[LATENCY-1];
    assign data_valid = r_vld[LATENCY-1];
    assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_mem_fill_responder.sv
// ============================================================================
//  Module      : tb_mem_fill_responder
//  Description : Directed self-checking bench for mem_fill_responder
//                (expected results follow MEM_RAW_FORWARD_EN when defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_fill_responder;

    localparam int LATENCY    = 4;
    localparam int DEPTH_LOG2 = 12;
`ifdef MEM_RAW_FORWARD_EN
    localparam logic [15:0] c_RAW_EXP = 16'h2222;
`else
    localparam logic [15:0] c_RAW_EXP = 16'h1111;
`endif

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        enable  = 1'b0;
    logic        wr      = 1'b0;
    logic [15:0] addr    = 16'h0000;
    logic [15:0] data_in = 16'h0000;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  pending;

    int n_checks = 0;
    int n_errors = 0;

    mem_fill_responder #(
        .LATENCY    (LATENCY),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .wr         (wr),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    task automatic check_resp(input string tag, input int c, input logic vld, input logic [15:0] dat);
        check($sformatf("%s_valid_c%0d", tag, c), {31'b0, data_valid}, {31'b0, vld});
        check($sformatf("%s_data_c%0d", tag, c), {16'b0, data_out}, {16'b0, dat});
    endtask

    initial begin
        int exp_pend;

        // Reset held with enable toggling
        #1 rst_n = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) begin
            drive(c[0], 1'b0, 16'h0010, 16'h0000);
            check_resp("reset", c, 1'b0, 16'h0000);
            check($sformatf("reset_pending_c%0d", c), {28'b0, pending}, 32'd0);
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Single read after write
        for (int c = 0; c < 7; c++) begin
            if (c == 0)      drive(1'b1, 1'b1, 16'h0010, 16'hBEEF);
            else if (c == 1) drive(1'b1, 1'b0, 16'h0010, 16'h0000);
            else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            check_resp("single", c, c == 5, (c == 5) ? 16'hBEEF : 16'h0000);
            check($sformatf("single_pending_c%0d", c), {28'b0, pending},
                  (c >= 2 && c <= 5) ? 32'd1 : 32'd0);
            tick();
        end

        // Block fill: writes in 0..7, back-to-back reads in 10..17
        for (int c = 0; c < 23; c++) begin
            if (c < 8)                 drive(1'b1, 1'b1, 16'h0040 + 16'(2*c), 16'h1000 + 16'(c));
            else if (c >= 10 && c < 18) drive(1'b1, 1'b0, 16'h0040 + 16'(2*(c-10)), 16'h0000);
            else                       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            exp_pend = 0;
            for (int i = 10; i < 18; i++) begin
                if (i <= c - 1 && i + LATENCY > c - 1) exp_pend++;
            end
            check_resp("fill", c, (c >= 14 && c <= 21),
                       (c >= 14 && c <= 21) ? 16'h1000 + 16'(c-14) : 16'h0000);
            check($sformatf("fill_pending_c%0d", c), {28'b0, pending}, 32'(exp_pend));
            tick();
        end

        // Write to a word with a read in flight
        drive(1'b1, 1'b1, 16'h0020, 16'h1111);
        tick();
        for (int c = 0; c < 6; c++) begin
            if (c == 0)      drive(1'b1, 1'b0, 16'h0020, 16'h0000);
            else if (c == 2) drive(1'b1, 1'b1, 16'h0020, 16'h2222);
            else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            check_resp("raw", c, c == 4, (c == 4) ? c_RAW_EXP : 16'h0000);
            tick();
        end
        drive(1'b1, 1'b0, 16'h0020, 16'h0000);
        tick();
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        check_resp("raw_after", 4, 1'b1, 16'h2222);
        tick();

        // Reset asserted mid-fill, held across edges 2 and 3
        for (int c = 0; c < 11; c++) begin
            if (c < 4) drive(1'b1, 1'b0, 16'h0040 + 16'(2*c), 16'h0000);
            else       drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            if (c == 2) begin
                check("midrst_pending_before", {28'b0, pending}, 32'd2);
                rst_n = 1'b0;
                #1;
            end
            if (c == 4) rst_n = 1'b1;
            check_resp("midrst", c, 1'b0, 16'h0000);
            if (c >= 2) check($sformatf("midrst_pending_c%0d", c), {28'b0, pending}, 32'd0);
            tick();
        end
        for (int c = 11; c < 17; c++) begin
            if (c == 11) drive(1'b1, 1'b0, 16'h0042, 16'h0000);
            else         drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            check_resp("postrst", c, c == 15, (c == 15) ? 16'h1001 : 16'h0000);
            tick();
        end

        // Odd address and upper-bit aliasing
        for (int c = 0; c < 8; c++) begin
            if (c == 0)      drive(1'b1, 1'b1, 16'h0003, 16'hA5A5);
            else if (c == 1) drive(1'b1, 1'b0, 16'h0002, 16'h0000);
            else if (c == 2) drive(1'b1, 1'b0, 16'h2002, 16'h0000);
            else             drive(1'b0, 1'b0, 16'h0000, 16'h0000);
            check_resp("alias", c, (c == 5 || c == 6), (c == 5 || c == 6) ? 16'hA5A5 : 16'h0000);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
